// File: rtl/ctrl_pkg.sv
// Shared Control Unit definitions: opcodes, FSM class indices, dispatcher
// state encoding and the class-to-one-hot helper.
package ctrl_pkg;

  localparam int unsigned N_FSM = 8;

  // RV32/RV64 major opcodes (insn[6:0])
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_IMM32   = 7'b0011011;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_LOADFP  = 7'b0000111;
  localparam logic [6:0] OP_STOREFP = 7'b0100111;
  localparam logic [6:0] OP_FP      = 7'b1010011;
  localparam logic [6:0] OP_FMADD   = 7'b1000011;
  localparam logic [6:0] OP_FMSUB   = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB  = 7'b1001011;
  localparam logic [6:0] OP_FNMADD  = 7'b1001111;

  // Specialised FSM indices
  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_LUI    = 3'd5;
  localparam logic [2:0] CLS_FPMEM  = 3'd6;
  localparam logic [2:0] CLS_FPOP   = 3'd7;

  // Dispatcher states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_WAIT_MEM  = 3'd2;
  localparam logic [2:0] ST_DECODE    = 3'd3;
  localparam logic [2:0] ST_ISSUE     = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;
  localparam logic [2:0] ST_TRAP      = 3'd6;

  function automatic logic [N_FSM-1:0] cls_onehot(input logic [2:0] c);
    logic [N_FSM-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/opclass_decode.sv
// Maps a major opcode to the index of the FSM that executes it.
module opclass_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] insn,
  output logic [2:0] cls,
  output logic       valid
);

  // Opcode-to-class lookup; anything unlisted is undecodable
  always_comb begin
    cls   = CLS_ALU;
    valid = 1'b1;
    case (insn)
      OP_OP, OP_OP32, OP_IMM, OP_IMM32, OP_AUIPC: cls = CLS_ALU;
      OP_LOAD:                                    cls = CLS_LOAD;
      OP_STORE:                                   cls = CLS_STORE;
      OP_BRANCH:                                  cls = CLS_BRANCH;
      OP_JAL, OP_JALR:                            cls = CLS_JUMP;
      OP_LUI:                                     cls = CLS_LUI;
      OP_LOADFP, OP_STOREFP:                      cls = CLS_FPMEM;
      OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: cls = CLS_FPOP;
      default:                                    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fsm_dispatch.sv
// Control Unit top sequencer: fetch, classify, start one FSM, wait for its
// done, count retirements, and trap on illegal opcodes or watchdog expiry.
module fsm_dispatch
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             fetch_start,
  input  logic             mem_ready,
  input  logic [31:0]      mem_insn,
  output logic [31:0]      insn,
  output logic [N_FSM-1:0] start,
  input  logic [N_FSM-1:0] done,
  output logic [2:0]       sel_fsm,
  output logic             busy,
  output logic             illegal,
  output logic             timeout,
  output logic             spurious,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [31:0]      r_insn;
  logic [2:0]       r_sel;
  logic             r_illegal;
  logic             r_timeout;
  logic             r_spurious;
  logic [CNT_W-1:0] r_retired;
  logic [WD_W-1:0]  r_wdog;

  logic [2:0]       w_cls;
  logic             w_valid;
  logic [N_FSM-1:0] w_sel_hot;
  logic             w_done_own;
  logic             w_done_other;

  opclass_decode u_dec (
    .insn  (r_insn[6:0]),
    .cls   (w_cls),
    .valid (w_valid)
  );

  // Split incoming done pulses into the owner's and everyone else's
  always_comb begin
    w_sel_hot    = cls_onehot(r_sel);
    w_done_own   = |(done & w_sel_hot);
    w_done_other = |(done & ~w_sel_hot);
  end

  // Dispatcher state machine, instruction register, watchdog and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_insn     <= '0;
      r_sel      <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
      r_spurious <= 1'b0;
      r_retired  <= '0;
      r_wdog     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_state <= ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          if (mem_ready) begin
            r_insn  <= mem_insn;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_valid && (r_insn[1:0] == 2'b11)) begin
            r_sel   <= w_cls;
            r_state <= ST_ISSUE;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= ST_TRAP;
          end
        end
        ST_ISSUE: begin
          r_wdog  <= '0;
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (w_done_other) r_spurious <= 1'b1;
          // completion is checked first so a done on the last watchdog cycle still retires
          if (w_done_own) begin
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= run ? ST_FETCH : ST_IDLE;
          end else if (r_wdog == WD_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_TRAP;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        ST_TRAP: begin
          r_state <= ST_TRAP;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes and status decoded from state and registers only
  always_comb begin
    fetch_start = (r_state == ST_FETCH);
    start       = (r_state == ST_ISSUE) ? w_sel_hot : '0;
    busy        = (r_state != ST_IDLE) && (r_state != ST_TRAP);
    insn        = r_insn;
    sel_fsm     = r_sel;
    illegal     = r_illegal;
    timeout     = r_timeout;
    spurious    = r_spurious;
    retired     = r_retired;
  end

endmodule

// File: tb/tb_fsm_dispatch.sv
// Directed bench for fsm_dispatch: opcode table plus multi-cycle sequences.
module tb_fsm_dispatch;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        fetch_start;
  logic        mem_ready;
  logic [31:0] mem_insn;
  logic [31:0] insn;
  logic [7:0]  start;
  logic [7:0]  done;
  logic [2:0]  sel_fsm;
  logic        busy;
  logic        illegal;
  logic        timeout;
  logic        spurious;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fsm_dispatch #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (rst),
    .run         (run),
    .fetch_start (fetch_start),
    .mem_ready   (mem_ready),
    .mem_insn    (mem_insn),
    .insn        (insn),
    .start       (start),
    .done        (done),
    .sel_fsm     (sel_fsm),
    .busy        (busy),
    .illegal     (illegal),
    .timeout     (timeout),
    .spurious    (spurious),
    .retired     (retired)
  );

  typedef struct packed {
    logic [31:0] insn;
    logic        valid;
    logic [2:0]  sel;
    logic [7:0]  exp_start;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b0;
    mem_insn  = '0;
    done      = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for either a start pulse or the illegal flag
  task automatic wait_ev(output logic [7:0] s, output logic [2:0] sl,
                         output logic il, output logic ok);
    int n;
    s  = '0;
    sl = '0;
    il = 1'b0;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (start != 8'h00 || illegal) begin
        s  = start;
        sl = sel_fsm;
        il = illegal;
        ok = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [7:0]  s;
    logic [2:0]  sl;
    logic        il;
    logic        ok;
    logic        flag;
    int          n;
    logic [31:0] seq_insn[3];
    logic [7:0]  seq_start[3];

    vecs[0]  = '{32'h002081B3, 1'b1, 3'd0, 8'h01};
    vecs[1]  = '{32'h0000003B, 1'b1, 3'd0, 8'h01};
    vecs[2]  = '{32'h00000013, 1'b1, 3'd0, 8'h01};
    vecs[3]  = '{32'h0000001B, 1'b1, 3'd0, 8'h01};
    vecs[4]  = '{32'h00000017, 1'b1, 3'd0, 8'h01};
    vecs[5]  = '{32'h0000A183, 1'b1, 3'd1, 8'h02};
    vecs[6]  = '{32'h0030A023, 1'b1, 3'd2, 8'h04};
    vecs[7]  = '{32'hFE208EE3, 1'b1, 3'd3, 8'h08};
    vecs[8]  = '{32'h0000006F, 1'b1, 3'd4, 8'h10};
    vecs[9]  = '{32'h00000067, 1'b1, 3'd4, 8'h10};
    vecs[10] = '{32'h00000037, 1'b1, 3'd5, 8'h20};
    vecs[11] = '{32'h00000007, 1'b1, 3'd6, 8'h40};
    vecs[12] = '{32'h00000027, 1'b1, 3'd6, 8'h40};
    vecs[13] = '{32'h00000053, 1'b1, 3'd7, 8'h80};
    vecs[14] = '{32'h00000043, 1'b1, 3'd7, 8'h80};
    vecs[15] = '{32'h00000047, 1'b1, 3'd7, 8'h80};
    vecs[16] = '{32'h0000004B, 1'b1, 3'd7, 8'h80};
    vecs[17] = '{32'h0000004F, 1'b1, 3'd7, 8'h80};
    vecs[18] = '{32'h00000000, 1'b0, 3'd0, 8'h00};
    vecs[19] = '{32'h00000073, 1'b0, 3'd0, 8'h00};
    vecs[20] = '{32'h00000032, 1'b0, 3'd0, 8'h00};
    vecs[21] = '{32'h0000007F, 1'b0, 3'd0, 8'h00};

    // Reset values while reset is held
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_insn = '0; done = '0;
    @(negedge clk);
    chk("rst_fetch_start", fetch_start, 0);
    chk("rst_start", start, 0);
    chk("rst_insn", insn, 0);
    chk("rst_sel", sel_fsm, 0);
    chk("rst_flags", {busy, illegal, timeout, spurious}, 0);
    chk("rst_retired", retired, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_fetch", {busy, fetch_start}, 0);

    // Opcode class table
    for (int i = 0; i < 22; i++) begin
      do_reset();
      run = 1'b1; mem_ready = 1'b1; mem_insn = vecs[i].insn;
      wait_ev(s, sl, il, ok);
      chk($sformatf("v%0d_event", i), ok, 1);
      chk($sformatf("v%0d_start", i), s, vecs[i].exp_start);
      chk($sformatf("v%0d_illegal", i), il, !vecs[i].valid);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_sel", i), sl, vecs[i].sel);
        @(negedge clk); done = vecs[i].exp_start;
        @(negedge clk); done = '0;
        chk($sformatf("v%0d_retired", i), retired, 1);
        chk($sformatf("v%0d_refetch", i), fetch_start, 1);
      end else begin
        chk($sformatf("v%0d_trap_busy", i), busy, 0);
      end
    end

    // add with done three cycles after start
    do_reset();
    run = 1'b1; mem_ready = 1'b1; mem_insn = 32'h002081B3;
    wait_ev(s, sl, il, ok);
    chk("add_start", s, 8'h01);
    flag = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (sel_fsm != 3'd0 || start != 8'h00 || !busy || fetch_start) flag = 1'b1;
      if (k == 3) done = 8'h01;
    end
    chk("add_wait_hold", flag, 0);
    @(negedge clk); done = '0;
    chk("add_retired", retired, 1);
    chk("add_refetch", fetch_start, 1);

    // lw, sw, beq back to back
    seq_insn[0] = 32'h0000A183; seq_start[0] = 8'h02;
    seq_insn[1] = 32'h0030A023; seq_start[1] = 8'h04;
    seq_insn[2] = 32'hFE208EE3; seq_start[2] = 8'h08;
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_insn = seq_insn[i];
      wait_ev(s, sl, il, ok);
      chk($sformatf("seq%0d_start", i), s, seq_start[i]);
      @(negedge clk); done = s;
      @(negedge clk); done = '0;
    end
    chk("seq_retired", retired, 3);

    // Illegal instruction parks in TRAP regardless of run
    do_reset();
    run = 1'b1; mem_ready = 1'b1; mem_insn = 32'h00000000;
    wait_ev(s, sl, il, ok);
    chk("ill_flag", il, 1);
    chk("ill_no_start", s, 0);
    chk("ill_busy", busy, 0);
    flag = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (start != 8'h00 || fetch_start || busy || !illegal) flag = 1'b1;
    end
    chk("ill_trap_hold", flag, 0);
    rst = 1'b1; #1;
    chk("trap_rst_illegal", illegal, 0);
    chk("trap_rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // Watchdog expiry: WAIT_DONE lasts exactly TO cycles
    do_reset();
    run = 1'b1; mem_ready = 1'b1; mem_insn = 32'h002081B3;
    wait_ev(s, sl, il, ok);
    n = 0;
    while (!timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, TO + 1);
    chk("to_flag", timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_retired", retired, 0);
    rst = 1'b1; #1;
    chk("to_rst_clear", timeout, 0);
    @(negedge clk); rst = 1'b0;

    // done on the last watchdog cycle wins over expiry
    do_reset();
    run = 1'b1; mem_ready = 1'b1; mem_insn = 32'h002081B3;
    wait_ev(s, sl, il, ok);
    repeat (TO) @(negedge clk);
    done = 8'h01;
    @(negedge clk); done = '0;
    chk("edge_no_timeout", timeout, 0);
    chk("edge_retired", retired, 1);

    // Spurious done, then run dropped before completion
    do_reset();
    run = 1'b1; mem_ready = 1'b1; mem_insn = 32'h002081B3;
    wait_ev(s, sl, il, ok);
    @(negedge clk); done = 8'h04;
    @(negedge clk); done = '0;
    chk("spur_flag", spurious, 1);
    chk("spur_still_busy", busy, 1);
    chk("spur_sel", sel_fsm, 0);
    run = 1'b0;
    @(negedge clk); done = 8'h01;
    @(negedge clk); done = '0;
    chk("spur_retired", retired, 1);
    chk("spur_parked", busy, 0);
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (fetch_start || busy || !spurious) flag = 1'b1;
    end
    chk("spur_no_refetch", flag, 0);

    // Asynchronous reset during WAIT_MEM
    do_reset();
    run = 1'b1; mem_ready = 1'b1; mem_insn = 32'h0000A183;
    wait_ev(s, sl, il, ok);
    @(negedge clk); done = 8'h02; mem_ready = 1'b0;
    @(negedge clk); done = '0;
    @(negedge clk);
    chk("wm_pre_state", {busy, fetch_start}, 2'b10);
    chk("wm_pre_sel", sel_fsm, 1);
    chk("wm_pre_insn", insn, 32'h0000A183);
    rst = 1'b1; #1;
    chk("wm_rst_retired", retired, 0);
    chk("wm_rst_insn", insn, 0);
    chk("wm_rst_sel", sel_fsm, 0);
    chk("wm_rst_strobes", {busy, fetch_start, start}, 0);
    @(negedge clk); rst = 1'b0; run = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_dispatch.md
Name: fsm_dispatch

Overview:
Top-level sequencer of the Control Unit. It fetches an instruction over the instruction-memory handshake, classifies it by opcode, pulses `start` to exactly one specialised FSM (ALU, load, store, branch, jump, LUI, FP-mem, FP-op), and waits for that FSM's `done`. While it waits, it drives the select that steers that FSM's control outputs onto the DataFlow. It also owns the retired-instruction counter, the watchdog and the trap flags.

Parameters:
N_FSM, 8, number of specialised FSMs; fixed by the class map, not user-changeable.
TIMEOUT, 64, maximum cycles allowed in WAIT_DONE before a watchdog trap; must be at least 2.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
run  in  1  level; 1 = keep fetching, 0 = park in IDLE after the current instruction.
fetch_start  out  1  one-cycle pulse requesting an instruction-memory read at the current PC.
mem_ready  in  1  instruction memory has valid data on mem_insn.
mem_insn  in  32  fetched instruction word.
insn  out  32  latched instruction register, fed to all FSMs and the opdecoder.
start  out  N_FSM  one-hot, one-cycle start pulse to the selected FSM.
done  in  N_FSM  done pulses from the FSMs.
sel_fsm  out  3  index of the FSM owning the control bus; muxes FSM outputs.
busy  out  1  1 in every state except IDLE and TRAP.
illegal  out  1  sticky; set on an undecodable instruction.
timeout  out  1  sticky; set on watchdog expiry.
spurious  out  1  sticky; set when a done bit arrives from a non-selected FSM.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset, asynchronous: state=IDLE, insn=0, start=0, fetch_start=0, sel_fsm=0, busy=0, illegal=0, timeout=0, spurious=0, retired=0, watchdog=0.
- States: IDLE, FETCH, WAIT_MEM, DECODE, ISSUE, WAIT_DONE, TRAP.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH: fetch_start=1 for exactly one cycle, then go to WAIT_MEM.
- WAIT_MEM: stays indefinitely with no timeout. On the first cycle with mem_ready=1, insn<=mem_insn and go to DECODE.
- DECODE: classify insn. Unmatched opcode or insn[1:0]!=2'b11 sets illegal=1 and goes to TRAP. Otherwise latch the class into sel_fsm and go to ISSUE.
- Class map (opcode insn[6:0] to index):
  - 0110011/0111011/0010011/0011011/0010111 -> 0 (ALU)
  - 0000011 -> 1
  - 0100011 -> 2
  - 1100011 -> 3
  - 1101111/1100111 -> 4
  - 0110111 -> 5
  - 0000111/0100111 -> 6
  - 1010011/1000011/1000111/1001011/1001111 -> 7
- ISSUE: start[sel_fsm]=1 for one cycle, clear watchdog, go to WAIT_DONE.
- WAIT_DONE:
  - sel_fsm held and watchdog increments each cycle.
  - done[sel_fsm]=1: retired+1 (wraps at 2^CNT_W), then FETCH if run=1, else IDLE.
  - Any other done bit set: spurious=1. It is not a trap; completion is unaffected.
  - Watchdog reaching TIMEOUT-1 without done: timeout=1, go to TRAP.
  - If done and expiry occur in the same cycle, done wins.
- TRAP: all strobes 0, busy=0. Stays until reset; run is ignored.
- run deasserting mid-instruction never aborts: the dispatcher completes through WAIT_DONE, then parks.
- Minimum latency, FETCH to the next FETCH with mem_ready already high: 5 cycles plus the FSM latency.
- Reset mid-operation returns to IDLE immediately. Any in-flight FSM must be reset by the same signal.
- All outputs are registered or decoded from state only; there is no combinational path from done or mem_ready to start or fetch_start.

Decomposition:
- Shared package ctrl_pkg holds:
  - the opcode localparams;
  - the class indices CLS_ALU..CLS_FPOP;
  - the dispatcher state encoding, 3-bit;
  - N_FSM.
- One combinational sub-module, opclass_decode: input insn[6:0], outputs cls[2:0] and valid. It is reusable by the opdecoder.

Test Plan:
- run=1, mem_insn=0x002081B3 (add x3,x1,x2), mem_ready high, done[0] returned 3 cycles after start -> start=8'h01 for one cycle, sel_fsm=0 throughout WAIT_DONE, retired=1, fetch_start re-pulses.
- Sequence 0x0000A183 (lw), 0x0030A023 (sw), 0xFE208EE3 (beq) -> start = 8'h02, 8'h04, 8'h08 in order; retired=3.
- mem_insn=0x00000000 -> illegal=1, state TRAP, no start pulse, busy=0; stays through 100 cycles of run=1.
- FSM never returns done -> timeout=1 exactly TIMEOUT cycles after ISSUE; TRAP entered; retired unchanged.
- done[2] pulsed while sel_fsm=0, then done[0] -> spurious=1, instruction still retires normally; run dropped during WAIT_DONE -> IDLE after done, no further fetch_start.
- Assert reset during WAIT_MEM and during TRAP -> all outputs at reset values in the same cycle (asynchronous); illegal and timeout cleared.
